// File: rtl/flash_pkg.sv
`default_nettype none
// ============================================================================
// flash_pkg : shared types and constants for the serial boot-flash reader
// Revision  : 1.0
// ============================================================================
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    ADDR      = 3'd2,
    FETCH_BIT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         FLASH_ADDR_W   = 24;

endpackage
`default_nettype wire

// File: rtl/flash_sclk_gen.sv
`default_nettype none
// ============================================================================
// flash_sclk_gen : registered SCLK divider with edge strobes and freeze input
// Revision       : 1.0
// ============================================================================
module flash_sclk_gen #(
  parameter int CLK_PERIOD     = 10,
  parameter int DUTY_THRESHOLD = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_hold,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int               CNT_W     = (CLK_PERIOD > 1) ? $clog2(CLK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLK_PERIOD - 1);
  localparam logic [CNT_W-1:0] C_DUTY    = CNT_W'(DUTY_THRESHOLD);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             r_sclk_d;

  // The delayed copy always tracks, so a freeze never repeats a strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_sclk   <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_d <= r_sclk;
      if (!i_run) begin
        r_cnt  <= '0;
        r_sclk <= 1'b0;
      end else if (!i_hold) begin
        r_sclk <= (r_cnt < C_DUTY);
        r_cnt  <= (r_cnt == C_CNT_MAX) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_sclk     = r_sclk;
  assign o_rise_stb =  r_sclk & ~r_sclk_d;
  assign o_fall_stb = ~r_sclk &  r_sclk_d;

endmodule
`default_nettype wire

// File: rtl/flash_bit_reader.sv
`default_nettype none
// ============================================================================
// flash_bit_reader : SPI mode-0 READ (0x03) master with byte valid/ready output
// Revision         : 1.0
// ============================================================================
module flash_bit_reader
  import flash_pkg::*;
#(
  parameter int CLK_PERIOD     = 10,
  parameter int DUTY_THRESHOLD = 5,
  parameter int LEN_W          = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FLASH_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]        req_len,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [7:0]              rd_data,
  output logic                    done,
  output logic                    flash_cs_n,
  output logic                    flash_clk,
  output logic                    flash_mosi,
  input  logic                    flash_miso
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [31:0]      r_tx;
  logic [4:0]       r_bit_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [7:0]       r_rx;
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic             r_pend;
  logic             r_rx_done;
  logic             r_cs_n;

  logic             w_rise;
  logic             w_fall;
  logic             w_run;
  logic             w_busy_nxt;
  logic             w_byte_done;
  logic             w_rd_take;
  logic [7:0]       w_rx_next;
  logic [LEN_W-1:0] w_byte_cnt_inc;

  assign w_run = ((r_state == CMD) || (r_state == ADDR) || (r_state == FETCH_BIT))
                 && !r_rx_done;

  flash_sclk_gen #(
    .CLK_PERIOD     (CLK_PERIOD),
    .DUTY_THRESHOLD (DUTY_THRESHOLD)
  ) u_sclk_gen (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_run),
    .i_hold     (r_pend),
    .o_sclk     (flash_clk),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  assign w_rx_next      = {r_rx[6:0], flash_miso};
  assign w_byte_cnt_inc = r_byte_cnt + 1'b1;
  assign w_rd_take      = r_rd_valid && rd_ready;
  assign w_byte_done    = (r_state == FETCH_BIT) && w_rise && !r_rx_done
                          && (r_bit_cnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_nxt = CMD;
      end
      CMD: begin
        if (w_fall && (r_bit_cnt == 5'd7)) w_state_nxt = ADDR;
      end
      ADDR: begin
        if (w_fall && (r_bit_cnt == 5'd31)) begin
          w_state_nxt = (r_len == '0) ? DONE : FETCH_BIT;
        end
      end
      FETCH_BIT: begin
        if (r_rx_done && !r_pend && (!r_rd_valid || rd_ready)) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == CMD) || (w_state_nxt == ADDR) ||
                      (w_state_nxt == FETCH_BIT);

  // TX/RX shifting and counters. The TX register shifts in zeros, so MOSI is
  // low through the data phase without a separate mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx       <= '0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_rx       <= '0;
      r_rx_done  <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_cs_n <= !w_busy_nxt;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tx       <= {FLASH_CMD_READ, req_addr};
            r_len      <= req_len;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rx_done  <= 1'b0;
          end
        end
        CMD, ADDR: begin
          if (w_fall) begin
            r_tx      <= {r_tx[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        FETCH_BIT: begin
          if (w_rise && !r_rx_done) begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt[2:0] == 3'd7) begin
              r_byte_cnt <= w_byte_cnt_inc;
              if (w_byte_cnt_inc == r_len) r_rx_done <= 1'b1;
            end
          end
        end
        default: begin
          r_tx <= '0;
        end
      endcase
    end
  end

  // A byte finishing while the output slot is still full parks in r_rx and
  // freezes SCLK until the consumer drains the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (w_byte_done) begin
        if (r_rd_valid && !rd_ready) begin
          r_pend <= 1'b1;
        end else begin
          r_rd_data  <= w_rx_next;
          r_rd_valid <= 1'b1;
        end
      end else if (r_pend && (!r_rd_valid || rd_ready)) begin
        r_rd_data  <= r_rx;
        r_rd_valid <= 1'b1;
        r_pend     <= 1'b0;
      end else if (w_rd_take) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign done       = (r_state == DONE);
  assign flash_cs_n = r_cs_n;
  assign flash_mosi = r_tx[31];
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;

endmodule
`default_nettype wire
